dm_store_rmw: RTL and testbench

- Store-side counterpart of the load-extension path in the MEM stage: accepts sw/sh/sb requests and commits them to a word-only data memory.
- Full-word stores are written directly.
- Byte and halfword stores use a read-modify-write sequence: read the word, merge the lane(s), write back.
- Sits between the MEM-stage store logic and the DM bus. The pipeline stalls on st_ready low.

---
 rtl/dm_store_rmw.sv | 169 ++++++++++++++++
 tb/tb_dm_store_rmw.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dm_store_rmw.sv
// Store unit for a word-only data memory: sw is written directly, while sb/sh
// read the word, merge the addressed lane(s) and write the result back.
module dm_store_rmw #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [1:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        done,
    output logic        align_err,
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t           state_reg;
    logic             st_ready_reg;
    logic             mem_req_reg;
    logic             mem_we_reg;
    logic [31:0]      mem_addr_reg;
    logic [31:0]      mem_wdata_reg;
    logic             done_reg;
    logic             align_err_reg;
    logic             bus_err_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [3:0]       be_reg;
    logic [31:0]      rep_reg;

    logic        accept;
    logic        misalign;
    logic        timeout_hit;
    logic [3:0]  be_next;
    logic [31:0] rep_next;
    logic [31:0] merged;

    assign accept      = st_valid && st_ready_reg;
    assign misalign    = (st_op == 2'b11) ||
                         (st_op == 2'b01 && st_addr[0]) ||
                         (st_op == 2'b10 && st_addr[1:0] != 2'b00);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_W'(TIMEOUT));

    // Lane enables and the store data replicated across all lanes, so the merge
    // below is a plain per-byte select.
    always_comb begin
        be_next  = 4'b0000;
        rep_next = {4{st_data[7:0]}};
        case (st_op)
            2'b00: be_next = 4'b0001 << st_addr[1:0];
            2'b01: begin
                be_next  = st_addr[1] ? 4'b1100 : 4'b0011;
                rep_next = {2{st_data[15:0]}};
            end
            default: begin
                be_next  = 4'b1111;
                rep_next = st_data;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[gi*8 +: 8] = be_reg[gi] ? rep_reg[gi*8 +: 8] : mem_rdata[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            st_ready_reg  <= 1'b1;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            done_reg      <= 1'b0;
            align_err_reg <= 1'b0;
            bus_err_reg   <= 1'b0;
            cnt_reg       <= '0;
            be_reg        <= '0;
            rep_reg       <= '0;
        end else begin
            done_reg      <= 1'b0;
            align_err_reg <= 1'b0;
            bus_err_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (misalign) begin
                            align_err_reg <= 1'b1;
                        end else begin
                            mem_addr_reg <= {st_addr[31:2], 2'b00};
                            be_reg       <= be_next;
                            rep_reg      <= rep_next;
                            cnt_reg      <= '0;
                            mem_req_reg  <= 1'b1;
                            st_ready_reg <= 1'b0;
                            if (st_op == 2'b10) begin
                                state_reg     <= WR;
                                mem_we_reg    <= 1'b1;
                                mem_wdata_reg <= st_data;
                            end else begin
                                state_reg  <= RD;
                                mem_we_reg <= 1'b0;
                            end
                        end
                    end
                end
                RD: begin
                    // Request stays up across RD->WR; only the direction and data change.
                    if (mem_ack) begin
                        state_reg     <= WR;
                        mem_we_reg    <= 1'b1;
                        mem_wdata_reg <= merged;
                        cnt_reg       <= '0;
                    end else if (timeout_hit) begin
                        state_reg    <= IDLE;
                        mem_req_reg  <= 1'b0;
                        st_ready_reg <= 1'b1;
                        bus_err_reg  <= 1'b1;
                    end else if (cnt_reg != '1) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                WR: begin
                    if (mem_ack) begin
                        state_reg    <= IDLE;
                        mem_req_reg  <= 1'b0;
                        mem_we_reg   <= 1'b0;
                        st_ready_reg <= 1'b1;
                        done_reg     <= 1'b1;
                    end else if (timeout_hit) begin
                        state_reg    <= IDLE;
                        mem_req_reg  <= 1'b0;
                        mem_we_reg   <= 1'b0;
                        st_ready_reg <= 1'b1;
                        bus_err_reg  <= 1'b1;
                    end else if (cnt_reg != '1) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    mem_req_reg  <= 1'b0;
                    mem_we_reg   <= 1'b0;
                    st_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign st_ready  = st_ready_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign done      = done_reg;
    assign align_err = align_err_reg;
    assign bus_err   = bus_err_reg;
endmodule

// File: tb/tb_dm_store_rmw.sv
// Bench for dm_store_rmw: a vector table of stores driven against a bus responder
// whose acked transactions are compared with a queue of expected bus operations.
module tb_dm_store_rmw;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        done;
    logic        align_err;
    logic        bus_err;

    dm_store_rmw #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_op(st_op),
        .st_addr(st_addr), .st_data(st_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .done(done), .align_err(align_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    // kind: 0 done, 1 align_err, 2 bus_err
    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          delay;
        int          kind;
        int          lat;
        int          reqs;
        logic [31:0] wdata;
    } vec_t;

    bus_t exp_q[$];
    int   passed = 0;
    int   total = 0;
    int   ack_delay = 0;
    int   wait_cnt = 0;
    int   req_cycles = 0;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Bus responder and scoreboard: acks after ack_delay request cycles.
    always @(negedge clk) begin
        bus_t e;
        mem_ack = 1'b0;
        if (mem_req) begin
            req_cycles++;
            if (wait_cnt == ack_delay) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
                if (exp_q.size() == 0) begin
                    check("bus_unexpected_req", {31'd0, mem_req}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("bus_we", {31'd0, mem_we}, {31'd0, e.we});
                    check("bus_addr", mem_addr, e.addr);
                    if (e.we) check("bus_wdata", mem_wdata, e.wdata);
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        int kind;
        int r0;
        logic [31:0] word;
        check($sformatf("v%0d_ready", idx), {31'd0, st_ready}, 32'd1);
        ack_delay = v.delay;
        mem_rdata = v.rdata;
        word = {v.addr[31:2], 2'b00};
        if (v.kind == 0) begin
            if (v.op != 2'b10) exp_q.push_back('{1'b0, word, 32'd0});
            exp_q.push_back('{1'b1, word, v.wdata});
        end
        r0 = req_cycles;
        st_valid = 1'b1;
        st_op    = v.op;
        st_addr  = v.addr;
        st_data  = v.data;
        @(negedge clk);
        // Garbage after accept must be ignored.
        st_valid = 1'b0;
        st_op    = 2'b10;
        st_addr  = 32'hFFFF_FFF0;
        st_data  = 32'h5A5A_5A5A;
        cyc  = 1;
        kind = 3;
        while (cyc <= 40) begin
            if (done || align_err || bus_err) begin
                kind = done ? 0 : (align_err ? 1 : 2);
                check($sformatf("v%0d_one_pulse", idx),
                      32'(done) + 32'(align_err) + 32'(bus_err), 32'd1);
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check($sformatf("v%0d_outcome", idx), kind, v.kind);
        check($sformatf("v%0d_latency", idx), cyc, v.lat);
        check($sformatf("v%0d_req_cycles", idx), req_cycles - r0, v.reqs);
        check($sformatf("v%0d_queue_left", idx), exp_q.size(), 0);
        check($sformatf("v%0d_req_dropped", idx), {31'd0, mem_req}, 32'd0);
        exp_q.delete();
    endtask

    initial begin
        reset_n   = 1'b0;
        st_valid  = 1'b0;
        st_op     = 2'b00;
        st_addr   = 32'd0;
        st_data   = 32'd0;
        mem_rdata = 32'd0;
        mem_ack   = 1'b0;

        //            op     addr          data          rdata         dly kind lat reqs wdata
        vecs[0]  = '{2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         0, 0, 2, 1, 32'hDEAD_BEEF};
        vecs[1]  = '{2'b00, 32'h0000_0203, 32'h0000_00AA, 32'h1122_3344, 0, 0, 3, 2, 32'hAA22_3344};
        vecs[2]  = '{2'b01, 32'h0000_0302, 32'h0000_BEEF, 32'h1122_3344, 0, 0, 3, 2, 32'hBEEF_3344};
        vecs[3]  = '{2'b01, 32'h0000_0300, 32'h0000_BEEF, 32'h1122_3344, 0, 0, 3, 2, 32'h1122_BEEF};
        vecs[4]  = '{2'b01, 32'h0000_0301, 32'h0000_BEEF, 32'h1122_3344, 0, 1, 1, 0, 32'h0};
        vecs[5]  = '{2'b10, 32'h0000_0102, 32'h1234_5678, 32'h0,         0, 1, 1, 0, 32'h0};
        vecs[6]  = '{2'b11, 32'h0000_0000, 32'h1234_5678, 32'h0,         0, 1, 1, 0, 32'h0};
        vecs[7]  = '{2'b00, 32'h0000_0200, 32'hFFFF_FF55, 32'h1122_3344, 0, 0, 3, 2, 32'h1122_3355};
        vecs[8]  = '{2'b00, 32'h0000_0201, 32'h0000_0055, 32'h1122_3344, 0, 0, 3, 2, 32'h1122_5544};
        vecs[9]  = '{2'b10, 32'h0000_0404, 32'h1234_5678, 32'h0,         2, 0, 4, 3, 32'h1234_5678};
        vecs[10] = '{2'b00, 32'h0000_0502, 32'h0000_0077, 32'hA0B0_C0D0, 1, 0, 5, 4, 32'hA077_C0D0};
        vecs[11] = '{2'b00, 32'h0000_0600, 32'h0000_0011, 32'h1122_3344, 255, 2, 6, 5, 32'h0};

        repeat (2) @(negedge clk);
        check("rst_st_ready", {31'd0, st_ready}, 32'd1);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_pulses", {29'd0, done, align_err, bus_err}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Consecutive vectors start in the cycle the previous pulse is seen,
        // so a new request is accepted in the same cycle done pulses.
        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Asynchronous reset in the middle of a write.
        ack_delay = 255;
        st_valid  = 1'b1;
        st_op     = 2'b10;
        st_addr   = 32'h0000_0700;
        st_data   = 32'hCAFE_F00D;
        @(negedge clk);
        st_valid = 1'b0;
        check("wr_req_up", {31'd0, mem_req}, 32'd1);
        check("wr_we_up", {31'd0, mem_we}, 32'd1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_mem_req", {31'd0, mem_req}, 32'd0);
        check("arst_st_ready", {31'd0, st_ready}, 32'd1);
        check("arst_mem_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("arst_no_done", {31'd0, done}, 32'd0);
        run_vec(12, '{2'b10, 32'h0000_0710, 32'h0BAD_F00D, 32'h0, 0, 0, 2, 1, 32'h0BAD_F00D});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
